mmcm_drp_reconfig: RTL and testbench
====================================

Name: mmcm_drp_reconfig

Overview:
- Sequencer that reprograms an MMCME2_ADV at run time through its dynamic reconfiguration port (DRP).
- On a start request it:
  - holds the MMCM in reset;
  - performs a read-modify-write of each register listed in an external configuration ROM;
  - releases reset and waits for LOCKED.
- Sits between the clocking wrapper and the control/register logic that selects output frequencies.

Parameters:
- NUM_REGS, 23, DRP register writes per configuration (1..127).
- CFG_SEL_W, 1, width of configuration-set select; ROM holds 2**CFG_SEL_W sets.
- DRDY_TIMEOUT, 255, cycles allowed between DEN and DRDY before error.
- LOCK_TIMEOUT, 65535, cycles allowed after reset release before LOCKED error.

Ports:
- clk  in  1  system clock; also drives MMCM DCLK.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; ignored unless in IDLE.
- cfg_sel  in  CFG_SEL_W  configuration set; sampled on accepted start.
- busy  out  1  high from accepted start until done/error.
- done  out  1  one-cycle pulse on successful lock.
- error  out  1  sticky; set on timeout; cleared by next accepted start.
- rom_addr  out  CFG_SEL_W+7  {cfg_sel_q, index}.
- rom_data  in  39  {daddr[38:32], mask[31:16], data[15:0]}; valid one cycle after rom_addr.
- mmcm_rst  out  1  to MMCM RST.
- mmcm_locked  in  1  MMCM LOCKED (asynchronous).
- daddr  out  7  DRP address.
- den  out  1  DRP enable, single-cycle pulse.
- dwe  out  1  DRP write enable; only with den.
- di  out  16  DRP write data.
- do_in  in  16  DRP read data, valid with drdy.
- drdy  in  1  DRP ready.

Behaviour:
- Reset values:
  - busy=0, done=0, error=0, mmcm_rst=0, den=0, dwe=0.
  - daddr=0, di=0, rom_addr=0.
  - index=0, state=IDLE.
- mmcm_locked passes through a 2-flop synchroniser (locked_s) before use.
- States and transitions:
  - IDLE: on start, latch cfg_sel, clear error, busy=1, index=0 -> ASSERT_RST.
  - ASSERT_RST: mmcm_rst=1 (held through WAIT_LOCK entry); drive rom_addr -> FETCH.
  - FETCH: one wait cycle for ROM latency; register rom_data into addr_q, mask_q, data_q -> RD_REQ.
  - RD_REQ: den=1, dwe=0, daddr=addr_q for exactly one cycle -> RD_WAIT.
  - RD_WAIT: on drdy, di <= (do_in & mask_q) | data_q -> WR_REQ.
  - WR_REQ: den=1, dwe=1, daddr=addr_q for one cycle -> WR_WAIT.
  - WR_WAIT:
    - on drdy, if index==NUM_REGS-1 -> RELEASE;
    - otherwise index+1, drive rom_addr -> FETCH.
  - RELEASE: mmcm_rst=0, clear timer -> WAIT_LOCK.
  - WAIT_LOCK: on locked_s -> IDLE with done=1 for one cycle and busy=0.
- Timeouts:
  - Timer clears on each den and on RELEASE.
  - In RD_WAIT/WR_WAIT, reaching DRDY_TIMEOUT: error=1, mmcm_rst=0, busy=0 -> IDLE. No further DRP access.
  - In WAIT_LOCK, reaching LOCK_TIMEOUT: error=1, busy=0 -> IDLE. No done pulse.
- No back-to-back DRP requests: den never asserts while a transaction is outstanding.
- drdy in any state other than RD_WAIT/WR_WAIT is ignored.
- start while busy is ignored; cfg_sel changes while busy have no effect.
- locked_s is ignored before RELEASE. Locked at the previous frequency does not shortcut the sequence.
- Asynchronous reset mid-sequence:
  - all outputs return to reset values immediately, including mmcm_rst=0;
  - the MMCM may hold a partial configuration; software must re-issue start.
- index width is 7 bits; rom_addr[6:0]=index, upper bits=cfg_sel_q.
- Timer width is clog2(max(DRDY_TIMEOUT, LOCK_TIMEOUT)+1) and saturates.

Decomposition:
- Shared package mmcm_drp_pkg holds:
  - the state enum;
  - the ROM entry field offsets (ADDR_HI=38, MASK_HI=31, DATA_HI=15);
  - a helper function computing the masked write value.
- One natural sub-module: sync_2ff for mmcm_locked. The configuration ROM lives outside this block.

Test Plan:
- Basic reprogram:
  - Stimulus: NUM_REGS=2, ROM entries {0x08, 0x1000, 0x0041} and {0x09, 0x8000, 0x0000}; DRP model returns 0xFFFF, drdy 3 cycles after den; locked 100 cycles after release.
  - Required: writes 0x1041 then 0x8000; exactly 4 den pulses; mmcm_rst high throughout the DRP phase; done pulse once, busy=0 afterwards.
- Set select: cfg_sel=1 -> rom_addr upper bit =1 for every fetch; cfg_sel toggled mid-run has no effect.
- DRDY timeout: drdy withheld after the first read -> error=1 at DRDY_TIMEOUT cycles; mmcm_rst=0; no dwe pulse; next start clears error.
- Lock timeout: LOCK_TIMEOUT=50, locked never rises -> error=1 after 50 cycles, no done pulse; locked rising at cycle 49 -> done instead.
- Start while busy and spurious drdy: start pulse in WR_WAIT and a drdy pulse in IDLE -> no second sequence; den count unchanged.
- Reset mid-operation: reset asserted in RD_WAIT -> all outputs 0 in the same cycle; a new start after release runs the full sequence from index 0.

Source files
------------

// File: rtl/mmcm_drp_pkg.sv
// Shared definitions for the MMCM DRP reconfiguration sequencer:
// FSM state encoding, configuration ROM entry field positions and the
// read-modify-write merge helper.
package mmcm_drp_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ASSERT_RST,
        S_FETCH,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_RELEASE,
        S_WAIT_LOCK
    } state_t;

    // ROM entry layout: {daddr[38:32], mask[31:16], data[15:0]}
    localparam int unsigned ADDR_HI = 38;
    localparam int unsigned ADDR_LO = 32;
    localparam int unsigned MASK_HI = 31;
    localparam int unsigned MASK_LO = 16;
    localparam int unsigned DATA_HI = 15;
    localparam int unsigned DATA_LO = 0;

    localparam int unsigned INDEX_W = 7;

    // Bits set in mask keep the current register contents; data supplies the rest.
    function automatic logic [15:0] masked_write(input logic [15:0] rd_val,
                                                 input logic [15:0] mask,
                                                 input logic [15:0] data);
        return (rd_val & mask) | data;
    endfunction

endpackage

// File: rtl/mmcm_drp_reconfig_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (MMCM LOCKED).
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset, clears both stages
//   d_i    - asynchronous input
//   q_o    - synchronised output (two cycles latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// Run-time MMCME2_ADV reprogramming sequencer. On an accepted start it holds
// the MMCM in reset, read-modify-writes every DRP register listed in the
// external configuration ROM, releases reset and waits for LOCKED.
// Ports:
//   clk, reset           - system clock (also MMCM DCLK), async active-high reset
//   start, cfg_sel       - one-cycle request and configuration set select
//   busy, done, error    - status: busy during sequence, done pulse, sticky error
//   rom_addr, rom_data   - configuration ROM ({cfg_sel, index} -> {addr,mask,data})
//   mmcm_rst, mmcm_locked- MMCM reset output and asynchronous LOCKED input
//   daddr, den, dwe, di, do_in, drdy - DRP interface
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 23,
    parameter int unsigned CFG_SEL_W    = 1,
    parameter int unsigned DRDY_TIMEOUT = 255,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CFG_SEL_W-1:0]   cfg_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [CFG_SEL_W+6:0]   rom_addr,
    input  logic [38:0]            rom_data,
    output logic                   mmcm_rst,
    input  logic                   mmcm_locked,
    output logic [6:0]             daddr,
    output logic                   den,
    output logic                   dwe,
    output logic [15:0]            di,
    input  logic [15:0]            do_in,
    input  logic                   drdy
);

    localparam int unsigned TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]      DRDY_LIM = TW'(DRDY_TIMEOUT - 1);
    localparam logic [TW-1:0]      LOCK_LIM = TW'(LOCK_TIMEOUT - 1);
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NUM_REGS - 1);

    state_t                 state_q, state_d;
    logic [CFG_SEL_W-1:0]   cfg_q, cfg_d;
    logic [INDEX_W-1:0]     index_q, index_d;
    logic [6:0]             addr_q, addr_d;
    logic [15:0]            mask_q, mask_d;
    logic [15:0]            data_q, data_d;
    logic [15:0]            di_q, di_d;
    logic [CFG_SEL_W+6:0]   rom_addr_q, rom_addr_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   rst_q, rst_d;
    logic                   den_q, den_d;
    logic                   dwe_q, dwe_d;
    logic                   locked_s;

    sync_2ff u_lock_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (mmcm_locked),
        .q_o   (locked_s)
    );

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        index_d    = index_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        data_d     = data_q;
        di_d       = di_q;
        rom_addr_d = rom_addr_q;
        error_d    = error_q;
        done_d     = 1'b0;
        timer_d    = (timer_q == '1) ? timer_q : timer_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d   = cfg_sel;
                    error_d = 1'b0;
                    index_d = '0;
                    state_d = S_ASSERT_RST;
                end
            end
            S_ASSERT_RST: begin
                rom_addr_d = {cfg_q, index_q};
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                addr_d  = rom_data[ADDR_HI:ADDR_LO];
                mask_d  = rom_data[MASK_HI:MASK_LO];
                data_d  = rom_data[DATA_HI:DATA_LO];
                state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                timer_d = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drdy) begin
                    di_d    = masked_write(do_in, mask_q, data_q);
                    state_d = S_WR_REQ;
                end else if (timer_q >= DRDY_LIM) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR_REQ: begin
                timer_d = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drdy) begin
                    if (index_q == LAST_IDX) begin
                        state_d = S_RELEASE;
                    end else begin
                        index_d    = index_q + 7'd1;
                        rom_addr_d = {cfg_q, index_q + 7'd1};
                        state_d    = S_FETCH;
                    end
                end else if (timer_q >= DRDY_LIM) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RELEASE: begin
                timer_d = '0;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (timer_q >= LOCK_LIM) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status/strobe registers are decoded from the next state so each
        // output is registered yet aligned with the state it belongs to.
        busy_d = (state_d != S_IDLE);
        rst_d  = state_d inside {S_ASSERT_RST, S_FETCH, S_RD_REQ, S_RD_WAIT,
                                 S_WR_REQ, S_WR_WAIT};
        den_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
        dwe_d  = (state_d == S_WR_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cfg_q      <= '0;
            index_q    <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            di_q       <= '0;
            rom_addr_q <= '0;
            timer_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rst_q      <= 1'b0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            index_q    <= index_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            di_q       <= di_d;
            rom_addr_q <= rom_addr_d;
            timer_q    <= timer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            rst_q      <= rst_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign mmcm_rst = rst_q;
    assign den      = den_q;
    assign dwe      = dwe_q;
    assign daddr    = addr_q;
    assign di       = di_q;
    assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
module tb_mmcm_drp_reconfig;

    logic        clk = 1'b0;
    logic        reset, start, mmcm_locked;
    logic [0:0]  cfg_sel;
    logic        busy, done, error, mmcm_rst, den, dwe, drdy;
    logic [7:0]  rom_addr;
    logic [38:0] rom_data;
    logic [6:0]  daddr;
    logic [15:0] di, do_in;

    logic [38:0] rom [0:255];
    logic        withhold, drdy_spur, drdy_model, exp_cfg;
    logic [15:0] rd_val;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];
    assign do_in    = rd_val;
    assign drdy     = drdy_model | drdy_spur;

    mmcm_drp_reconfig #(
        .NUM_REGS     (2),
        .CFG_SEL_W    (1),
        .DRDY_TIMEOUT (20),
        .LOCK_TIMEOUT (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_sel     (cfg_sel),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .mmcm_rst    (mmcm_rst),
        .mmcm_locked (mmcm_locked),
        .daddr       (daddr),
        .den         (den),
        .dwe         (dwe),
        .di          (di),
        .do_in       (do_in),
        .drdy        (drdy)
    );

    // DRP slave model and bus monitor: drdy 3 cycles after den.
    int          pend = 0, run_rd = 0;
    int          den_cnt = 0, dwe_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int          bad_rst = 0, bad_rom = 0, bad_overlap = 0;
    bit          outst = 1'b0;
    logic [6:0]  wr_addr [0:63];
    logic [15:0] wr_data [0:63];

    always @(negedge clk) begin
        drdy_model = 1'b0;
        if (reset) begin
            pend  = 0;
            outst = 1'b0;
        end else begin
            if (!busy) begin
                run_rd = 0;
                outst  = 1'b0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0 && !withhold) begin
                    drdy_model = 1'b1;
                    outst      = 1'b0;
                end
            end
            if (dwe) dwe_cnt++;
            if (done) done_cnt++;
            if (den) begin
                if (outst) bad_overlap++;
                outst = 1'b1;
                den_cnt++;
                pend = 3;
                if (!mmcm_rst) bad_rst++;
                if (dwe) begin
                    if (wr_cnt < 64) begin
                        wr_addr[wr_cnt] = daddr;
                        wr_data[wr_cnt] = di;
                    end
                    wr_cnt++;
                end else begin
                    if (rom_addr != {exp_cfg, 7'(run_rd)}) bad_rom++;
                    run_rd++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {27'd0, busy, done, error, mmcm_rst, den, dwe, daddr, di, rom_addr};
    endfunction

    function automatic logic [38:0] ent(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        return {a, m, d};
    endfunction

    task automatic start_run(input logic c, input bit hold);
        exp_cfg     = c;
        cfg_sel     = c;
        mmcm_locked = hold;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cfg_sel = ~c;
    endtask

    // Returns at the first cycle with mmcm_rst low (RELEASE).
    task automatic wait_release(output bit ok);
        int n;
        n = 0;
        while (mmcm_rst && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = !mmcm_rst && busy;
    endtask

    task automatic finish_lock(input int delay, output bit got);
        int n;
        repeat (delay) @(negedge clk);
        mmcm_locked = 1'b1;
        got = 1'b0;
        n   = 0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
        if (got) begin
            chk("busy_low_at_done", busy, 0);
            @(negedge clk);
            chk("done_single_cycle", done, 0);
        end
        mmcm_locked = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic        c;
        logic [15:0] rd;
        bit          hold;
        logic [6:0]  a0;
        logic [15:0] w0;
        logic [6:0]  a1;
        logic [15:0] w1;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok, gd;
        int d0, w0, dw0, dn0, br0, bm0, n;

        reset = 1'b1; start = 1'b0; cfg_sel = 1'b0; mmcm_locked = 1'b0;
        withhold = 1'b0; drdy_spur = 1'b0; exp_cfg = 1'b0; rd_val = 16'hFFFF;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[8'h00] = ent(7'h08, 16'h1000, 16'h0041);
        rom[8'h01] = ent(7'h09, 16'h8000, 16'h0000);
        rom[8'h80] = ent(7'h10, 16'h00FF, 16'h1200);
        rom[8'h81] = ent(7'h11, 16'hF0F0, 16'h0101);

        vecs[0] = '{1'b0, 16'hFFFF, 1'b0, 7'h08, 16'h1041, 7'h09, 16'h8000};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 7'h08, 16'h0041, 7'h09, 16'h0000};
        vecs[2] = '{1'b1, 16'hFFFF, 1'b0, 7'h10, 16'h12FF, 7'h11, 16'hF1F1};
        vecs[3] = '{1'b1, 16'h1234, 1'b0, 7'h10, 16'h1234, 7'h11, 16'h1131};
        vecs[4] = '{1'b0, 16'hA5A5, 1'b1, 7'h08, 16'h0041, 7'h09, 16'h8000};

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_outputs", outs(), 0);

        // Table-driven full reprogram runs.
        for (int i = 0; i < 5; i++) begin
            rd_val = vecs[i].rd;
            d0 = den_cnt; w0 = wr_cnt; dw0 = dwe_cnt; dn0 = done_cnt;
            br0 = bad_rst; bm0 = bad_rom;
            start_run(vecs[i].c, vecs[i].hold);
            wait_release(ok);
            chk($sformatf("vec%0d_release", i), 64'(ok), 1);
            finish_lock(vecs[i].hold ? 0 : 30, gd);
            chk($sformatf("vec%0d_done", i), 64'(gd), 1);
            chk($sformatf("vec%0d_den_count", i), 64'(den_cnt - d0), 4);
            chk($sformatf("vec%0d_dwe_count", i), 64'(dwe_cnt - dw0), 2);
            chk($sformatf("vec%0d_writes", i),
                {wr_addr[w0], wr_data[w0], wr_addr[w0+1], wr_data[w0+1]},
                {vecs[i].a0, vecs[i].w0, vecs[i].a1, vecs[i].w1});
            chk($sformatf("vec%0d_done_pulses", i), 64'(done_cnt - dn0), 1);
            chk($sformatf("vec%0d_rst_during_drp", i), 64'(bad_rst - br0), 0);
            chk($sformatf("vec%0d_rom_addr", i), 64'(bad_rom - bm0), 0);
            chk($sformatf("vec%0d_status", i), {busy, error}, 0);
        end

        // DRDY timeout on the first read.
        withhold = 1'b1;
        d0 = den_cnt; dw0 = dwe_cnt;
        start_run(1'b0, 1'b0);
        n = 0;
        while (!den && n < 20) begin @(negedge clk); n++; end
        chk("drdy_to_first_den", 64'(den), 1);
        repeat (20) @(negedge clk);
        chk("drdy_to_before", {error, busy, mmcm_rst}, 3'b011);
        @(negedge clk);
        chk("drdy_to_after", {error, busy, mmcm_rst}, 3'b100);
        repeat (5) @(negedge clk);
        chk("drdy_to_den_count", 64'(den_cnt - d0), 1);
        chk("drdy_to_no_dwe", 64'(dwe_cnt - dw0), 0);
        withhold = 1'b0;
        start_run(1'b0, 1'b0);
        chk("error_cleared_on_start", {error, busy}, 2'b01);
        wait_release(ok);
        finish_lock(10, gd);
        chk("after_drdy_to_done", {64'(gd), error}, 2);

        // Lock never rises.
        dn0 = done_cnt;
        start_run(1'b0, 1'b0);
        wait_release(ok);
        chk("lock_to_release", 64'(ok), 1);
        repeat (50) @(negedge clk);
        chk("lock_to_before", {error, busy}, 2'b01);
        @(negedge clk);
        chk("lock_to_after", {error, busy}, 2'b10);
        repeat (5) @(negedge clk);
        chk("lock_to_no_done", 64'(done_cnt - dn0), 0);

        // Lock arriving just inside the window.
        start_run(1'b1, 1'b0);
        wait_release(ok);
        finish_lock(48, gd);
        chk("lock_late_done", {64'(gd), error}, 2);

        // Start while busy and drdy while idle.
        d0 = den_cnt; dn0 = done_cnt; w0 = wr_cnt;
        start_run(1'b0, 1'b0);
        n = 0;
        while (wr_cnt == w0 && n < 100) begin @(negedge clk); n++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_release(ok);
        finish_lock(10, gd);
        chk("poke_done", 64'(gd), 1);
        drdy_spur = 1'b1;
        @(negedge clk);
        drdy_spur = 1'b0;
        repeat (10) @(negedge clk);
        chk("poke_idle", {busy, mmcm_rst}, 0);
        chk("poke_den_count", 64'(den_cnt - d0), 4);
        chk("poke_done_count", 64'(done_cnt - dn0), 1);

        // Asynchronous reset in RD_WAIT, then a clean rerun.
        start_run(1'b1, 1'b0);
        n = 0;
        while (!den && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("pre_reset_busy", {busy, mmcm_rst}, 2'b11);
        reset = 1'b1;
        #1;
        chk("reset_mid_outputs", outs(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_val = 16'hFFFF;
        d0 = den_cnt; w0 = wr_cnt;
        start_run(1'b0, 1'b0);
        wait_release(ok);
        finish_lock(20, gd);
        chk("rerun_done", 64'(gd), 1);
        chk("rerun_den_count", 64'(den_cnt - d0), 4);
        chk("rerun_writes",
            {wr_addr[w0], wr_data[w0], wr_addr[w0+1], wr_data[w0+1]},
            {7'h08, 16'h1041, 7'h09, 16'h8000});

        chk("no_overlapping_den", 64'(bad_overlap), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
